// File: rtl/muldiv_unit.sv
// HI/LO unit for the execute stage: fixed-latency multiply, 32-step restoring divide,
// and mthi/mtlo writes. Stalls EX until a multiply/divide result is committed.
module muldiv_unit #(
   parameter int MUL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        is_mult,
   input  logic        is_multu,
   input  logic        is_div,
   input  logic        is_divu,
   input  logic        hi_wen,
   input  logic        lo_wen,
   input  logic        flush,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = (MUL_CYCLES > 32) ? $clog2(MUL_CYCLES) : 5;
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(31);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t        state, state_next;
   logic [CW-1:0] counter;
   logic [31:0]   op_a, op_b;
   logic          op_signed;
   logic [31:0]   quo, rem, dvs;
   logic          neg_q, neg_r;

   logic          accept, last_cycle;
   logic [63:0]   mul_a, mul_b, product;
   logic [32:0]   rem_shift;
   logic          fits;
   logic [31:0]   rem_step, quo_step, quo_fix, rem_fix;

   // stall holds the EX instruction; it drops in the final busy cycle so the
   // instruction leaves EX on the same edge that HI/LO take the result.
   always_comb begin
      accept     = (state == IDLE) & op_valid & (is_mult | is_multu | is_div | is_divu) & ~flush;
      last_cycle = ((state == MUL) && (counter == MUL_LAST)) ||
                   ((state == DIV) && (counter == DIV_LAST));
      stall      = ~flush & (accept | ((state != IDLE) & ~last_cycle));
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (is_mult | is_multu) ? MUL : DIV;
         MUL,
         DIV:     if (flush || last_cycle) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Low 64 bits of the product of sign/zero-extended operands.
   always_comb begin
      mul_a   = {{32{op_signed & op_a[31]}}, op_a};
      mul_b   = {{32{op_signed & op_b[31]}}, op_b};
      product = mul_a * mul_b;
   end

   // One restoring step on magnitudes; the fixups apply only to the final step.
   always_comb begin
      rem_shift = {rem, quo[31]};
      fits      = rem_shift >= {1'b0, dvs};
      rem_step  = fits ? (rem_shift[31:0] - dvs) : rem_shift[31:0];
      quo_step  = {quo[30:0], fits};
      quo_fix   = neg_q ? (~quo_step + 32'd1) : quo_step;
      rem_fix   = neg_r ? (~rem_step + 32'd1) : rem_step;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         counter   <= '0;
         hi        <= '0;
         lo        <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_signed <= 1'b0;
         quo       <= '0;
         rem       <= '0;
         dvs       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               counter <= '0;
               if (accept) begin
                  op_a      <= src_a;
                  op_b      <= src_b;
                  op_signed <= is_mult;
                  quo       <= (is_div & src_a[31]) ? (~src_a + 32'd1) : src_a;
                  dvs       <= (is_div & src_b[31]) ? (~src_b + 32'd1) : src_b;
                  rem       <= '0;
                  neg_q     <= is_div & (src_a[31] ^ src_b[31]);
                  neg_r     <= is_div & src_a[31];
               end else if (op_valid && !flush) begin
                  if (hi_wen) hi <= src_a;
                  if (lo_wen) lo <= src_a;
               end
            end
            MUL: begin
               counter <= counter + CW'(1);
               if (last_cycle && !flush) {hi, lo} <= product;
            end
            DIV: begin
               counter <= counter + CW'(1);
               rem     <= rem_step;
               quo     <= quo_step;
               if (last_cycle && !flush) begin
                  lo <= quo_fix;
                  hi <= rem_fix;
               end
            end
            default: counter <= '0;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage HI/LO unit for the mipsel32 core. Downstream consumer of the decoder's is_mult/is_multu/is_div/is_divu/lo_wen/hi_wen strobes.
- Takes rs/rt operands from EX and holds the architectural HI/LO registers.
- Runs multiply (fixed latency) and 32-step restoring divide. Stalls EX until the result is committed.
- hi/lo outputs feed the mfhi/mflo result mux (is_result_hi/is_result_lo).

Parameters:
- MUL_CYCLES, 1, cycles spent in MUL state after the accept cycle (>=1).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  EX holds a valid instruction
- is_mult  input  1  signed multiply
- is_multu  input  1  unsigned multiply
- is_div  input  1  signed divide
- is_divu  input  1  unsigned divide
- hi_wen  input  1  mthi
- lo_wen  input  1  mtlo
- flush  input  1  exception/eret cancel of EX instruction
- src_a  input  32  rs_data (dividend / multiplicand / mthi-mtlo data)
- src_b  input  32  rt_data (divisor / multiplier)
- stall  output  1  hold EX and upstream stages
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE; hi=0, lo=0, stall=0, counter=0. Reset mid-operation aborts the operation with the same values.
- States: IDLE, MUL, DIV.
- Accept (IDLE only): op_valid & (is_mult|is_multu|is_div|is_divu) & ~flush.
  - Latch operands and signedness; go to MUL (counter=0) or DIV (counter=0).
- Priority: mul/div over hi_wen/lo_wen if both are asserted.
- mthi/mtlo (IDLE only): op_valid & ~flush & hi_wen writes hi<=src_a at the edge; lo_wen likewise writes lo. Both may write in the same cycle.
- In MUL/DIV, all op inputs are ignored; the stalled EX instruction keeps presenting them.
- MUL:
  - Product = 64-bit of {sign/zero-ext 33b a} * {33b b}; signed when is_mult, unsigned when is_multu.
  - Counter increments each cycle. At counter==MUL_CYCLES-1: {hi,lo}<=product, go to IDLE.
- DIV:
  - Operate on magnitudes (abs when is_div, raw when is_divu).
  - One restoring step per cycle, MSB first: rem={rem,next bit}; if rem>=divisor then subtract and set quotient bit.
  - At counter==31: lo<=quotient, hi<=remainder (after sign fixup), go to IDLE.
  - Sign fixup (is_div only): quotient negated if sign(a)^sign(b); remainder takes the sign of a.
  - Divide-by-zero: no special case; the natural algorithm output is the required result. Raw quotient 0xFFFFFFFF, remainder |a|, then sign fixup.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps).
- stall (combinational) = ~flush & (accept_cond | (state!=IDLE & ~last_cycle)).
  - last_cycle = MUL & counter==MUL_CYCLES-1, or DIV & counter==31.
  - HI/LO update on the same edge that the instruction leaves EX. A following mfhi/mflo reads the new value with no forwarding.
- Occupancy:
  - mult: 1+MUL_CYCLES cycles, stall high for MUL_CYCLES of them.
  - div: 33 cycles, stall high for 32 of them.
- flush in MUL/DIV: go to IDLE next edge; hi/lo unchanged; stall=0 that cycle.
- flush in IDLE: blocks both accept and mthi/mtlo writes.
- A new accept is possible in the cycle immediately after return to IDLE.

Test Plan:
- mult a=0xFFFFFFFF b=2 -> hi=0xFFFFFFFF lo=0xFFFFFFFE. multu with same operands -> hi=0x00000001 lo=0xFFFFFFFE. With MUL_CYCLES=1, stall high exactly 1 cycle.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. stall high exactly 32 consecutive cycles; hi/lo unchanged until the 33rd edge. Back-to-back mflo sees 0xFFFFFFFD.
- Corner divides:
  - divu 0x80000000/0 -> lo=0xFFFFFFFF hi=0x80000000.
  - div 0xFFFFFFF9/0 -> lo=0x00000001 hi=0xFFFFFFF9.
  - div 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
  - divu 100/7 -> lo=14 hi=2.
- Preload hi=0xAAAA lo=0x5555. Start div, assert flush at iteration 10 -> stall=0 that cycle; hi/lo stay 0xAAAA/0x5555. Next cycle, mtlo 0x1234 is accepted -> lo=0x1234.
- mthi src_a=0x1234 op_valid=1 -> hi=0x1234 next cycle, lo unchanged. hi_wen=1 with op_valid=0 -> no write. hi_wen with flush=1 -> no write.
- reset asserted at div iteration 5 -> next cycle hi=lo=0, stall=0, state IDLE. A new mult is accepted the following cycle.
